tile_map_writer: RTL and testbench
==================================

Name: tile_map_writer

Overview:
- Write-side engine for the dual-clock tile RAM. The pixel drawer reads tile codes from the RAM's read port; this block drives the write port (data, write address, write enable).
- Runs in the game-logic clock domain. Accepts tile-level draw commands over a valid/ready handshake: single tile, filled rectangle, or full-screen clear.
- Converts each command into one RAM write per cycle in raster order.
- Performs an automatic blank-screen sweep after reset, so the display never shows uninitialised RAM.

Parameters:
- RAM_DATA_WIDTH, 7, tile code width; matches the tile RAM data width.
- RAM_ADDR_WIDTH, 9, tile RAM address width.
- MAP_COLS, 20, tiles per row (640/32).
- MAP_ROWS, 15, tile rows (480/32).
- BLANK_TILE, 0, tile code written by the post-reset sweep.

Ports:
- clk_i  input  1  game-logic clock; also the RAM write clock.
- rst_i  input  1  synchronous, active-high reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  block can accept a command; high only in IDLE.
- cmd_op_i  input  2  0=WRITE, 1=RECT, 2=CLEAR, 3=reserved.
- cmd_row_i  input  4  start tile row.
- cmd_col_i  input  5  start tile column.
- cmd_h_i  input  4  RECT height in tiles.
- cmd_w_i  input  5  RECT width in tiles.
- cmd_tile_i  input  RAM_DATA_WIDTH  tile code to write.
- data_o  output  RAM_DATA_WIDTH  RAM write data.
- write_addr_o  output  RAM_ADDR_WIDTH  RAM write address.
- we_o  output  1  RAM write enable.
- busy_o  output  1  high whenever the state is not IDLE.
- done_o  output  1  one-cycle pulse coincident with the last write of a command.
- err_o  output  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset state on any clock edge with rst_i=1:
  - we_o=0, write_addr_o=0, data_o=0, cmd_ready_o=0, done_o=0, err_o=0, busy_o=1.
  - State goes to SWEEP with tile code BLANK_TILE.
- Reset mid-command aborts the command immediately; no further writes for it. The sweep restarts from address 0.
- States:
  - SWEEP: writes BLANK_TILE to addresses 0 .. MAP_COLS*MAP_ROWS-1, one per cycle (300 cycles by default). The final write returns to IDLE; done_o is not pulsed.
  - IDLE: cmd_ready_o=1. A command is accepted on a cycle with cmd_valid_i && cmd_ready_o. cmd_ready_o drops the cycle after acceptance. All command fields are captured at acceptance.
  - WRITE: cycle after acceptance: we_o=1, write_addr_o=row*MAP_COLS+col, data_o=tile, done_o=1. Then returns to IDLE, so cmd_ready_o is high 2 cycles after acceptance.
  - RECT:
    - Write order: row-major from (row,col), w*h writes, one per cycle, starting the cycle after acceptance.
    - Address advances by 1 within a row. At the end of a row it jumps to the next row's start (row base + MAP_COLS); this is a registered row base, with no multiply per write.
    - done_o is asserted with the last write.
  - CLEAR: like SWEEP but writes cmd_tile_i, and pulses done_o on the final write (address MAP_COLS*MAP_ROWS-1).
  - REJECT: one cycle with err_o=1 and we_o=0, then IDLE.
- Rejection conditions (no write ever issued):
  - op=3.
  - WRITE or RECT with row>=MAP_ROWS or col>=MAP_COLS.
  - RECT with w=0 or h=0.
  - RECT overflow, handled per the optional feature below.
- Address arithmetic:
  - Computed at RAM_ADDR_WIDTH bits.
  - Never exceeds MAP_COLS*MAP_ROWS-1 for any accepted command.
  - Out-of-map addresses (300..511) are never written.
- we_o is low in every cycle that does not carry a valid write.
- data_o and write_addr_o may hold stale values when we_o=0.
- busy_o equals !cmd_ready_o outside reset.

Optional Feature:
- Macro: TILE_MAP_WRITER_CLIP_EN.
- Defined: a RECT extending past the right or bottom edge is clipped.
  - Effective width = min(w, MAP_COLS-col); effective height = min(h, MAP_ROWS-row).
  - Only the clipped tiles are written, and done_o is asserted on the last clipped write.
- Undefined: any RECT with col+w>MAP_COLS or row+h>MAP_ROWS is rejected via REJECT (err_o pulse, zero writes).

Test Plan:
- Reset sweep: deassert rst_i → exactly 300 consecutive we_o cycles, addresses 0..299, data 0. cmd_ready_o rises the cycle after the address-299 write. done_o stays 0 throughout.
- WRITE row=2, col=5, tile=7'h41 → single we_o cycle, addr 45, data 0x41, done_o in the same cycle. cmd_ready_o is high again 2 cycles after acceptance.
- RECT row=1, col=18, h=2, w=2, tile=3:
  - Without macro: writes addr 38, 39, 58, 59 on 4 consecutive cycles; done_o on 59.
  - Same command with col=19, without macro: err_o pulse, 0 writes.
  - Same command with col=19, with macro: writes addr 39, 59; done_o on 59.
- Illegal commands each produce one err_o pulse and no we_o:
  - op=3.
  - WRITE row=15, col=0.
  - RECT w=0.
- rst_i asserted for 1 cycle during the 10th write of a 6x6 RECT → no further RECT writes. A fresh sweep starts at addr 0 with data BLANK_TILE.
- Held cmd_valid_i back-to-back: two WRITE commands presented continuously → second accepted only once cmd_ready_o returns. Writes are ≥2 cycles apart and neither command is lost or duplicated.

Source files
------------

// File: rtl/tile_map_writer.sv
// tile_map_writer
// ---------------
// Write-side engine for the dual-clock tile RAM. Turns tile-level draw
// commands (single tile, filled rectangle, full-screen clear) into one RAM
// write per cycle in raster order, and blanks the whole map after reset so
// the display never shows uninitialised RAM.
//
// Handshake: a command is accepted on any rising clk_i edge where
// cmd_valid_i && cmd_ready_o. All command fields are captured at that edge.
// cmd_ready_o is high only in IDLE and drops the cycle after acceptance.
//
// Ports:
//   clk_i         game-logic clock, also the RAM write clock
//   rst_i         synchronous, active-high reset (restarts the blank sweep)
//   cmd_valid_i   command present
//   cmd_ready_o   block can accept a command (IDLE only)
//   cmd_op_i      0=WRITE, 1=RECT, 2=CLEAR, 3=reserved (rejected)
//   cmd_row_i     start tile row
//   cmd_col_i     start tile column
//   cmd_h_i       RECT height in tiles
//   cmd_w_i       RECT width in tiles
//   cmd_tile_i    tile code to write
//   data_o        RAM write data
//   write_addr_o  RAM write address
//   we_o          RAM write enable
//   busy_o        high whenever not IDLE
//   done_o        one-cycle pulse with the last write of a command
//   err_o         one-cycle pulse when a command is rejected
//
// Build option:
//   TILE_MAP_WRITER_CLIP_EN  when defined, a RECT running past the right or
//                            bottom edge is clipped to the map instead of
//                            being rejected.
//
// All outputs are registered: the values computed for a cycle appear on the
// outputs the cycle after the edge that decided them.

module tile_map_writer #(
    parameter int RAM_DATA_WIDTH = 7,
    parameter int RAM_ADDR_WIDTH = 9,
    parameter int MAP_COLS       = 20,
    parameter int MAP_ROWS       = 15,
    parameter int BLANK_TILE     = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [3:0]                cmd_row_i,
    input  logic [4:0]                cmd_col_i,
    input  logic [3:0]                cmd_h_i,
    input  logic [4:0]                cmd_w_i,
    input  logic [RAM_DATA_WIDTH-1:0] cmd_tile_i,
    output logic [RAM_DATA_WIDTH-1:0] data_o,
    output logic [RAM_ADDR_WIDTH-1:0] write_addr_o,
    output logic                      we_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int AW = RAM_ADDR_WIDTH;
    localparam int DW = RAM_DATA_WIDTH;

    localparam logic [AW-1:0] COLS_A    = AW'(MAP_COLS);
    localparam logic [AW-1:0] ROWS_A    = AW'(MAP_ROWS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAP_COLS * MAP_ROWS - 1);
    localparam logic [DW-1:0] BLANK     = DW'(BLANK_TILE);

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_RECT  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;

    // LAST: the final write of a sweep/command is on the outputs; the next
    // edge returns to IDLE, so cmd_ready_o rises the cycle after that write.
    typedef enum logic [2:0] {
        ST_SWEEP,
        ST_IDLE,
        ST_RECT,
        ST_CLEAR,
        ST_LAST,
        ST_REJECT
    } state_t;

    state_t          state_q, state_n;
    logic            we_q, we_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [DW-1:0]   data_q, data_n;
    logic            done_q, done_n;
    logic            err_q, err_n;
    logic            ready_q, ready_n;

    // Rectangle walk: row_base is the address of the current row's first
    // tile, so moving to the next row is one add of MAP_COLS.
    logic [AW-1:0]   row_base_q, row_base_n;
    logic [4:0]      col_cnt_q, col_cnt_n;   // tiles written in current row
    logic [3:0]      row_left_q, row_left_n; // rows still to start after this one
    logic [4:0]      w_q, w_n;               // effective rectangle width

    // Command decode (combinational on the command inputs)
    logic [AW-1:0]   row_a, col_a, start_addr;
    logic            in_map, rect_fits, rect_ok;
    logic [4:0]      w_eff;
    logic [3:0]      h_eff;
    logic            accept;

    assign row_a      = AW'(cmd_row_i);
    assign col_a      = AW'(cmd_col_i);
    assign start_addr = row_a * COLS_A + col_a;
    assign in_map     = (row_a < ROWS_A) && (col_a < COLS_A);

`ifdef TILE_MAP_WRITER_CLIP_EN
    // Room left to the right/bottom edge; only meaningful when in_map holds,
    // which also guarantees it is at least 1.
    logic [4:0] room_w;
    logic [3:0] room_h;
    assign room_w    = 5'(MAP_COLS) - cmd_col_i;
    assign room_h    = 4'(MAP_ROWS) - cmd_row_i;
    assign w_eff     = (cmd_w_i > room_w) ? room_w : cmd_w_i;
    assign h_eff     = (cmd_h_i > room_h) ? room_h : cmd_h_i;
    assign rect_fits = 1'b1;
`else
    assign w_eff     = cmd_w_i;
    assign h_eff     = cmd_h_i;
    assign rect_fits = (col_a + AW'(cmd_w_i) <= COLS_A) &&
                       (row_a + AW'(cmd_h_i) <= ROWS_A);
`endif

    assign rect_ok = in_map && (cmd_w_i != 5'd0) && (cmd_h_i != 4'd0) && rect_fits;
    assign accept  = cmd_valid_i && ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_SWEEP;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            row_base_q <= '0;
            col_cnt_q  <= '0;
            row_left_q <= '0;
            w_q        <= '0;
        end else begin
            state_q    <= state_n;
            we_q       <= we_n;
            addr_q     <= addr_n;
            data_q     <= data_n;
            done_q     <= done_n;
            err_q      <= err_n;
            ready_q    <= ready_n;
            row_base_q <= row_base_n;
            col_cnt_q  <= col_cnt_n;
            row_left_q <= row_left_n;
            w_q        <= w_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        we_n       = 1'b0;
        addr_n     = addr_q;
        data_n     = data_q;
        done_n     = 1'b0;
        err_n      = 1'b0;
        ready_n    = 1'b0;
        row_base_n = row_base_q;
        col_cnt_n  = col_cnt_q;
        row_left_n = row_left_q;
        w_n        = w_q;

        case (state_q)
            ST_SWEEP: begin
                // First sweep write follows reset (we_q low, addr 0).
                we_n   = 1'b1;
                addr_n = we_q ? (addr_q + 1'b1) : '0;
                data_n = BLANK;
                if (addr_n == LAST_ADDR) begin
                    state_n = ST_LAST;
                end
            end

            ST_IDLE: begin
                ready_n = 1'b1;
                if (accept) begin
                    ready_n = 1'b0;
                    case (cmd_op_i)
                        OP_WRITE: begin
                            if (in_map) begin
                                we_n    = 1'b1;
                                addr_n  = start_addr;
                                data_n  = cmd_tile_i;
                                done_n  = 1'b1;
                                state_n = ST_LAST;
                            end else begin
                                err_n   = 1'b1;
                                state_n = ST_REJECT;
                            end
                        end
                        OP_RECT: begin
                            if (rect_ok) begin
                                we_n       = 1'b1;
                                addr_n     = start_addr;
                                data_n     = cmd_tile_i;
                                row_base_n = start_addr;
                                col_cnt_n  = 5'd1;
                                row_left_n = h_eff - 4'd1;
                                w_n        = w_eff;
                                if ((w_eff == 5'd1) && (h_eff == 4'd1)) begin
                                    done_n  = 1'b1;
                                    state_n = ST_LAST;
                                end else begin
                                    state_n = ST_RECT;
                                end
                            end else begin
                                err_n   = 1'b1;
                                state_n = ST_REJECT;
                            end
                        end
                        OP_CLEAR: begin
                            we_n   = 1'b1;
                            addr_n = '0;
                            data_n = cmd_tile_i;
                            if (LAST_ADDR == '0) begin
                                done_n  = 1'b1;
                                state_n = ST_LAST;
                            end else begin
                                state_n = ST_CLEAR;
                            end
                        end
                        default: begin
                            err_n   = 1'b1;
                            state_n = ST_REJECT;
                        end
                    endcase
                end
            end

            ST_RECT: begin
                we_n = 1'b1;
                if (col_cnt_q == w_q) begin
                    row_base_n = row_base_q + COLS_A;
                    addr_n     = row_base_q + COLS_A;
                    col_cnt_n  = 5'd1;
                    row_left_n = row_left_q - 4'd1;
                end else begin
                    addr_n    = addr_q + 1'b1;
                    col_cnt_n = col_cnt_q + 5'd1;
                end
                if ((row_left_n == 4'd0) && (col_cnt_n == w_q)) begin
                    done_n  = 1'b1;
                    state_n = ST_LAST;
                end
            end

            ST_CLEAR: begin
                we_n   = 1'b1;
                addr_n = addr_q + 1'b1;
                if (addr_n == LAST_ADDR) begin
                    done_n  = 1'b1;
                    state_n = ST_LAST;
                end
            end

            ST_LAST, ST_REJECT: begin
                ready_n = 1'b1;
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    assign we_o         = we_q;
    assign write_addr_o = addr_q;
    assign data_o       = data_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign cmd_ready_o  = ready_q;
    assign busy_o       = !ready_q;

endmodule

// File: tb/tb_tile_map_writer.sv
// Testbench for tile_map_writer. Expected writes are packed as
// {done, addr, data}, pushed into exp_q when a command is issued and popped
// by the write monitor each cycle the DUT asserts we_o.

module tb_tile_map_writer;

    localparam int DW   = 7;
    localparam int AW   = 9;
    localparam int COLS = 20;
    localparam int ROWS = 15;
    localparam int SIZE = COLS * ROWS;
    localparam int EW   = 1 + AW + DW;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op;
    logic [3:0]    cmd_row;
    logic [4:0]    cmd_col;
    logic [3:0]    cmd_h;
    logic [4:0]    cmd_w;
    logic [DW-1:0] cmd_tile;
    logic [DW-1:0] data_o;
    logic [AW-1:0] write_addr_o;
    logic          we_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int cycle = 0;
    logic [EW-1:0] exp_q[$];
    int wr_cyc_q[$];

    tile_map_writer #(
        .RAM_DATA_WIDTH(DW),
        .RAM_ADDR_WIDTH(AW),
        .MAP_COLS(COLS),
        .MAP_ROWS(ROWS),
        .BLANK_TILE(0)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op),
        .cmd_row_i(cmd_row),
        .cmd_col_i(cmd_col),
        .cmd_h_i(cmd_h),
        .cmd_w_i(cmd_w),
        .cmd_tile_i(cmd_tile),
        .data_o(data_o),
        .write_addr_o(write_addr_o),
        .we_o(we_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (err_o === 1'b1) err_seen++;
        if (we_o === 1'b1) begin
            wr_cyc_q.push_back(cycle);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h done=%0b, required no write",
                         write_addr_o, data_o, done_o);
            end else begin
                e = exp_q.pop_front();
                if ({done_o, write_addr_o, data_o} !== e) begin
                    errors++;
                    $display("FAIL write: got done=%0b addr=%0d data=%0h, required done=%0b addr=%0d data=%0h",
                             done_o, write_addr_o, data_o, e[EW-1], e[EW-2:DW], e[DW-1:0]);
                end
            end
        end else begin
            checks++;
            if (done_o !== 1'b0) begin
                errors++;
                $display("FAIL done_without_write: got done=%0b, required 0", done_o);
            end
        end
    end

    // ---------------- model / drivers ----------------
    task automatic push_exp(input bit done, input int addr, input logic [DW-1:0] tile);
        logic [AW-1:0] a;
        a = AW'(addr);
        exp_q.push_back({done, a, tile});
    endtask

    task automatic expect_cmd(input logic [1:0] op, input int row, input int col,
                              input int h, input int w, input logic [DW-1:0] tile,
                              output int exp_err);
        int we_, he_;
        exp_err = 0;
        case (op)
            2'd0: begin
                if (row < ROWS && col < COLS) push_exp(1'b1, row * COLS + col, tile);
                else exp_err = 1;
            end
            2'd1: begin
                if (row >= ROWS || col >= COLS || w == 0 || h == 0) begin
                    exp_err = 1;
                end else begin
                    we_ = w;
                    he_ = h;
`ifdef TILE_MAP_WRITER_CLIP_EN
                    if (col + w > COLS) we_ = COLS - col;
                    if (row + h > ROWS) he_ = ROWS - row;
`else
                    if (col + w > COLS || row + h > ROWS) exp_err = 1;
`endif
                    if (exp_err == 0) begin
                        for (int r = 0; r < he_; r++)
                            for (int c = 0; c < we_; c++)
                                push_exp((r == he_ - 1) && (c == we_ - 1),
                                         (row + r) * COLS + col + c, tile);
                    end
                end
            end
            2'd2: begin
                for (int a = 0; a < SIZE; a++) push_exp(a == SIZE - 1, a, tile);
            end
            default: exp_err = 1;
        endcase
    endtask

    task automatic send_cmd(input logic [1:0] op, input int row, input int col,
                            input int h, input int w, input logic [DW-1:0] tile);
        bit ok;
        @(negedge clk);
        cmd_op    = op;
        cmd_row   = 4'(row);
        cmd_col   = 5'(col);
        cmd_h     = 4'(h);
        cmd_w     = 5'(w);
        cmd_tile  = tile;
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (cmd_ready_o === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got cmd_ready_o=%0b, required 1 within 1000 cycles", cmd_ready_o);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready_o === 1'b1 && exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0 || cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL drain_%s: got pending=%0d ready=%0b, required pending=0 ready=1",
                     name, exp_q.size(), cmd_ready_o);
            exp_q.delete();
        end
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input int row,
                           input int col, input int h, input int w,
                           input logic [DW-1:0] tile);
        int e, err0;
        err0 = err_seen;
        expect_cmd(op, row, col, h, w, tile, e);
        send_cmd(op, row, col, h, w, tile);
        wait_drain(name);
        checks++;
        if (err_seen - err0 != e) begin
            errors++;
            $display("FAIL err_%s: got err pulses=%0d, required %0d", name, err_seen - err0, e);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int gaps, early;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_row = '0; cmd_col = '0; cmd_h = '0; cmd_w = '0; cmd_tile = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({we_o, write_addr_o, data_o, cmd_ready_o, done_o, err_o, busy_o} !==
            {1'b0, 9'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got we=%0b addr=%0d data=%0h ready=%0b done=%0b err=%0b busy=%0b, required 0 0 0 0 0 0 1",
                     we_o, write_addr_o, data_o, cmd_ready_o, done_o, err_o, busy_o);
        end
        for (int a = 0; a < SIZE; a++) push_exp(1'b0, a, '0);
        rst = 1'b0;
        gaps = 0;
        early = 0;
        for (int i = 0; i < SIZE; i++) begin
            @(negedge clk);
            if (we_o !== 1'b1) gaps++;
            if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) early++;
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL sweep_consecutive: got %0d idle cycles, required 0", gaps);
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL sweep_busy: got %0d cycles ready during sweep, required 0", early);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready_o !== 1'b1 || we_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end: got ready=%0b we=%0b busy=%0b, required 1 0 0",
                     cmd_ready_o, we_o, busy_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sweep_count: got %0d writes missing, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_write;
        int e;
        expect_cmd(2'd0, 2, 5, 0, 0, 7'h41, e);
        send_cmd(2'd0, 2, 5, 0, 0, 7'h41);
        @(negedge clk);
        checks++;
        if (we_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL write_cycle1: got we=%0b ready=%0b, required 1 0", we_o, cmd_ready_o);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready_o !== 1'b1 || we_o !== 1'b0) begin
            errors++;
            $display("FAIL write_cycle2: got ready=%0b we=%0b, required 1 0", cmd_ready_o, we_o);
        end
        wait_drain("write");
    endtask

    task automatic test_rect;
        run_cmd("rect_38",  2'd1, 1, 18, 2, 2, 7'd3);
        run_cmd("rect_c19", 2'd1, 1, 19, 2, 2, 7'd3);
        run_cmd("rect_bot", 2'd1, 14, 0, 3, 2, 7'd9);
        run_cmd("rect_1x1", 2'd1, 14, 19, 1, 1, 7'h7f);
        run_cmd("rect_col", 2'd1, 3, 7, 4, 1, 7'h15);
    endtask

    task automatic test_illegal;
        run_cmd("op3",       2'd3, 0, 0, 1, 1, 7'd1);
        run_cmd("write_r15", 2'd0, 15, 0, 0, 0, 7'd1);
        run_cmd("write_c20", 2'd0, 0, 20, 0, 0, 7'd1);
        run_cmd("rect_w0",   2'd1, 0, 0, 1, 0, 7'd1);
        run_cmd("rect_h0",   2'd1, 0, 0, 0, 3, 7'd1);
    endtask

    task automatic test_clear;
        run_cmd("clear", 2'd2, 0, 0, 0, 0, 7'h2a);
    endtask

    task automatic test_reset_mid_rect;
        bit found;
        int n;
        n = 0;
        for (int r = 0; r < 6 && n < 10; r++)
            for (int c = 0; c < 6 && n < 10; c++) begin
                push_exp(1'b0, (2 + r) * COLS + 3 + c, 7'h33);
                n++;
            end
        send_cmd(2'd1, 2, 3, 6, 6, 7'h33);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (we_o === 1'b1 && write_addr_o == 9'd66) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_rect_10th: got no write at addr 66, required one");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (we_o !== 1'b0 || cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_rect_reset: got we=%0b ready=%0b busy=%0b, required 0 0 1",
                     we_o, cmd_ready_o, busy_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_rect_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end
        for (int a = 0; a < SIZE; a++) push_exp(1'b0, a, '0);
        rst = 1'b0;
        wait_drain("resweep");
    endtask

    task automatic test_back_to_back;
        int e;
        bit ok;
        expect_cmd(2'd0, 0, 1, 0, 0, 7'h11, e);
        expect_cmd(2'd0, 3, 19, 0, 0, 7'h22, e);
        wr_cyc_q.delete();
        @(negedge clk);
        cmd_op = 2'd0; cmd_row = 4'd0; cmd_col = 5'd1; cmd_tile = 7'h11;
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready_o === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1;
        cmd_row = 4'd3; cmd_col = 5'd19; cmd_tile = 7'h22;
        @(negedge clk);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready_o === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 cmd_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_accept: got ready=%0b, required 1 within 20 cycles", cmd_ready_o);
        end
        wait_drain("b2b");
        checks++;
        if (wr_cyc_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes, required 2", wr_cyc_q.size());
        end else begin
            checks++;
            if (wr_cyc_q[1] - wr_cyc_q[0] < 2) begin
                errors++;
                $display("FAIL b2b_gap: got %0d cycles, required >= 2", wr_cyc_q[1] - wr_cyc_q[0]);
            end
        end
    endtask

    task automatic test_random;
        logic [1:0] op;
        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd2 && i > 2) op = 2'd1;
            run_cmd("random", op, $urandom_range(0, 15), $urandom_range(0, 21),
                    $urandom_range(0, 5), $urandom_range(0, 6),
                    7'($urandom_range(0, 127)));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_rect();
        test_illegal();
        test_clear();
        test_reset_mid_rect();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
